// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the hazard scoreboard slice.
//   entryFlags_t   : per-entry control flags carried down the shadow pipeline
//   FWD_RF         : forwarding select value meaning "take the register file"
//   PC_REG_DEFAULT : default architectural address of the PC register
//   fwdSelWidth()  : width of one forwarding select for a given stage count
package hazard_pkg;

    localparam int FWD_RF = 0;
    localparam logic [3:0] PC_REG_DEFAULT = 4'hF;

    typedef struct packed {
        logic valid;
        logic we;
        logic load;
        logic pcwr;
    } entryFlags_t;

    localparam int FLAG_W = $bits(entryFlags_t);

    // A select must encode 0 (register file) plus one code per stage.
    function automatic int fwdSelWidth(input int nfwd);
        return $clog2(nfwd + 1);
    endfunction

endpackage

// File: rtl/hz_entry_reg.sv
// hz_entry_reg
// One shadow-pipeline entry register.
//   clk     : clock
//   reset   : asynchronous active-low reset, clears the entry
//   clear_i : synchronous bubble, loads an all-zero (invalid) entry
//   d_i     : next entry contents
//   q_o     : registered entry contents
module hz_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] entry_q;

    // An all-zero entry is an invalid bubble, so reset and clear share it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q <= '0;
        end else if (clear_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= d_i;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard and forwarding controller with its own shadow pipeline of
// destination descriptors (E, then S1..S_NFWD).
//   clk, reset            : clock, asynchronous active-low reset
//   valid_d .. pcwr_d     : Decode instruction descriptor
//   cond_ok_e             : Execute instruction condition passed
//   branch_taken_e        : Execute branch redirects the PC
//   fwd_sel_e             : per read port, 0 = regfile, k = stage S_k
//   stall_f, stall_d      : hold PC / hold Decode register
//   flush_d, flush_e      : clear Decode / bubble into Execute
//   we_w, load_w, pcsrc_w : writeback controls from S_NFWD
//   wa_w                  : writeback address from S_NFWD
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int              AW       = 4,
    parameter int              NRP      = 2,
    parameter int              NFWD     = 2,
    parameter int              LOAD_LAT = 1,
    parameter logic [AW-1:0]   PC_REG   = AW'(PC_REG_DEFAULT),
    parameter int              FW       = fwdSelWidth(NFWD)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_d,
    input  logic [NRP*AW-1:0]   ra_d,
    input  logic [NRP-1:0]      ra_used_d,
    input  logic [AW-1:0]       wa_d,
    input  logic                we_d,
    input  logic                load_d,
    input  logic                pcwr_d,
    input  logic                cond_ok_e,
    input  logic                branch_taken_e,
    output logic [NRP*FW-1:0]   fwd_sel_e,
    output logic                stall_f,
    output logic                stall_d,
    output logic                flush_d,
    output logic                flush_e,
    output logic                we_w,
    output logic                load_w,
    output logic                pcsrc_w,
    output logic [AW-1:0]       wa_w
);

    localparam int CW = FLAG_W + AW;
    localparam int SW = NRP * AW + NRP;

    logic [CW-1:0]     stage_q [0:NFWD];
    logic [NRP*AW-1:0] eRa_q;
    logic [NRP-1:0]    eRaUsed_q;
    entryFlags_t       flags [0:NFWD];
    logic [AW-1:0]     wa [0:NFWD];
    logic [CW-1:0]     decodeEntry_d;
    logic [CW-1:0]     s1Entry_d;
    logic              ldStall;
    logic              pcwrPend;

    // Unpack the registered entries into flags and destination address.
    always_comb begin
        for (int k = 0; k <= NFWD; k++) begin
            flags[k] = entryFlags_t'(stage_q[k][CW-1 -: FLAG_W]);
            wa[k]    = stage_q[k][AW-1:0];
        end
    end

    // E keeps the unqualified write flags; the condition is applied only
    // when the instruction leaves E, because it is resolved in Execute.
    always_comb begin
        entryFlags_t dFlags;
        entryFlags_t s1Flags;
        dFlags        = '{valid: valid_d, we: we_d, load: load_d, pcwr: pcwr_d};
        decodeEntry_d = {dFlags, wa_d};
        s1Flags       = flags[0];
        s1Flags.we    = flags[0].we & cond_ok_e;
        s1Flags.pcwr  = flags[0].pcwr & cond_ok_e;
        s1Entry_d     = {s1Flags, wa[0]};
    end

    // Only E needs the source addresses, so only its register carries them.
    for (genvar k = 0; k <= NFWD; k++) begin : g_stage
        if (k == 0) begin : g_exec
            logic [CW+SW-1:0] execQ;
            hz_entry_reg #(.W(CW + SW)) u_entry (
                .clk     (clk),
                .reset   (reset),
                .clear_i (flush_e | ~valid_d),
                .d_i     ({decodeEntry_d, ra_d, ra_used_d}),
                .q_o     (execQ)
            );
            assign stage_q[0] = execQ[SW +: CW];
            assign eRa_q      = execQ[NRP +: NRP*AW];
            assign eRaUsed_q  = execQ[NRP-1:0];
        end else begin : g_post
            hz_entry_reg #(.W(CW)) u_entry (
                .clk     (clk),
                .reset   (reset),
                .clear_i (1'b0),
                .d_i     ((k == 1) ? s1Entry_d : stage_q[k-1]),
                .q_o     (stage_q[k])
            );
        end
    end

    // Scanning from the oldest stage down lets the youngest writer win.
    always_comb begin
        logic [AW-1:0] raI;
        fwd_sel_e = '0;
        for (int i = 0; i < NRP; i++) begin
            raI = eRa_q[i*AW +: AW];
            fwd_sel_e[i*FW +: FW] = FW'(FWD_RF);
            for (int k = NFWD; k >= 1; k--) begin
                if (eRaUsed_q[i] && (raI != PC_REG) && flags[k].valid &&
                    flags[k].we && (wa[k] == raI) &&
                    (!flags[k].load || (k > LOAD_LAT))) begin
                    fwd_sel_e[i*FW +: FW] = FW'(k);
                end
            end
        end
    end

    // A load still too young to forward blocks a dependent in Decode.
    always_comb begin
        logic [AW-1:0] raI;
        ldStall = 1'b0;
        for (int i = 0; i < NRP; i++) begin
            raI = ra_d[i*AW +: AW];
            for (int j = 0; j <= NFWD; j++) begin
                if ((j < LOAD_LAT) && ra_used_d[i] && (raI != PC_REG) &&
                    flags[j].valid && flags[j].we && flags[j].load &&
                    (wa[j] == raI)) begin
                    ldStall = 1'b1;
                end
            end
        end
        ldStall = ldStall & valid_d;
    end

    // Fetch waits for any PC writer that has not yet reached writeback.
    always_comb begin
        pcwrPend = valid_d & pcwr_d;
        for (int k = 0; k < NFWD; k++) begin
            pcwrPend = pcwrPend | (flags[k].valid & flags[k].pcwr);
        end
    end

    assign pcsrc_w = flags[NFWD].valid & flags[NFWD].pcwr;
    assign we_w    = flags[NFWD].valid & flags[NFWD].we;
    assign load_w  = flags[NFWD].load;
    assign wa_w    = wa[NFWD];

    assign stall_f = ldStall | pcwrPend;
    assign stall_d = ldStall;
    assign flush_e = ldStall | branch_taken_e;
    assign flush_d = pcwrPend | pcsrc_w | branch_taken_e;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard: instance A uses the default
// parameters, instance B uses NFWD=3, LOAD_LAT=2.
module tb_hazard_scoreboard;

    logic clk;
    logic reset;

    logic       aValid, aWe, aLoad, aPcwr, aCond, aBranch;
    logic [7:0] aRa;
    logic [1:0] aUsed;
    logic [3:0] aWa;
    logic [3:0] aFwd;
    logic       aStallF, aStallD, aFlushD, aFlushE, aWeW, aLoadW, aPcsrcW;
    logic [3:0] aWaW;

    logic       bValid, bWe, bLoad, bPcwr, bCond, bBranch;
    logic [7:0] bRa;
    logic [1:0] bUsed;
    logic [3:0] bWa;
    logic [3:0] bFwd;
    logic       bStallF, bStallD, bFlushD, bFlushE, bWeW, bLoadW, bPcsrcW;
    logic [3:0] bWaW;

    int compared;
    int mismatched;

    hazard_scoreboard dutA (
        .clk(clk), .reset(reset),
        .valid_d(aValid), .ra_d(aRa), .ra_used_d(aUsed), .wa_d(aWa),
        .we_d(aWe), .load_d(aLoad), .pcwr_d(aPcwr),
        .cond_ok_e(aCond), .branch_taken_e(aBranch),
        .fwd_sel_e(aFwd), .stall_f(aStallF), .stall_d(aStallD),
        .flush_d(aFlushD), .flush_e(aFlushE), .we_w(aWeW),
        .load_w(aLoadW), .pcsrc_w(aPcsrcW), .wa_w(aWaW)
    );

    hazard_scoreboard #(.NFWD(3), .LOAD_LAT(2)) dutB (
        .clk(clk), .reset(reset),
        .valid_d(bValid), .ra_d(bRa), .ra_used_d(bUsed), .wa_d(bWa),
        .we_d(bWe), .load_d(bLoad), .pcwr_d(bPcwr),
        .cond_ok_e(bCond), .branch_taken_e(bBranch),
        .fwd_sel_e(bFwd), .stall_f(bStallF), .stall_d(bStallD),
        .flush_d(bFlushD), .flush_e(bFlushE), .we_w(bWeW),
        .load_w(bLoadW), .pcsrc_w(bPcsrcW), .wa_w(bWaW)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a Decode descriptor into instance A and let it settle.
    task automatic applyStimulus(input logic v, input logic [3:0] ra0,
                                 input logic [3:0] ra1, input logic [1:0] used,
                                 input logic [3:0] wa, input logic we,
                                 input logic ld, input logic pcwr);
        aValid = v; aRa = {ra1, ra0}; aUsed = used; aWa = wa;
        aWe = we; aLoad = ld; aPcwr = pcwr;
        #1;
    endtask

    task automatic applyStimulusB(input logic v, input logic [3:0] ra0,
                                  input logic [1:0] used, input logic [3:0] wa,
                                  input logic ld);
        bValid = v; bRa = {4'd0, ra0}; bUsed = used; bWa = wa;
        bWe = v; bLoad = ld; bPcwr = 1'b0;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        reset = 1'b0;
        aValid = 0; aRa = '0; aUsed = '0; aWa = '0; aWe = 0; aLoad = 0;
        aPcwr = 0; aCond = 1; aBranch = 0;
        bValid = 0; bRa = '0; bUsed = '0; bWa = '0; bWe = 0; bLoad = 0;
        bPcwr = 0; bCond = 1; bBranch = 0;

        // Reset state, before any clock edge.
        #2;
        checkOutput("rst_fwd", aFwd, 0);
        checkOutput("rst_stall_f", aStallF, 0);
        checkOutput("rst_flush_d", aFlushD, 0);
        checkOutput("rst_we_w", aWeW, 0);
        checkOutput("rst_wa_w", aWaW, 0);

        tick;
        reset = 1'b1;

        // ADD r1 ; ADD r2,r1,r3 -> forward port0 from S1.
        applyStimulus(1, 4'd2, 4'd3, 2'b11, 4'd1, 1, 0, 0);
        checkOutput("add1_stall_f", aStallF, 0);
        tick;
        applyStimulus(1, 4'd1, 4'd3, 2'b11, 4'd2, 1, 0, 0);
        checkOutput("add2_stall_d", aStallD, 0);
        tick;
        checkOutput("alu_fwd_s1", aFwd, 4'b0001);

        // LDR r4 ; SUB r5,r4,r4 -> one stall, then forward both from S2.
        applyStimulus(1, 4'd0, 4'd0, 2'b01, 4'd4, 1, 1, 0);
        tick;
        checkOutput("wb_add1_we", aWeW, 1);
        checkOutput("wb_add1_wa", aWaW, 1);
        applyStimulus(1, 4'd4, 4'd4, 2'b11, 4'd5, 1, 0, 0);
        checkOutput("ld_stall_f", aStallF, 1);
        checkOutput("ld_stall_d", aStallD, 1);
        checkOutput("ld_flush_e", aFlushE, 1);
        checkOutput("ld_flush_d", aFlushD, 0);
        tick;
        checkOutput("ld_stall_end", aStallD, 0);
        checkOutput("ld_flush_e_end", aFlushE, 0);
        checkOutput("wb_add2_wa", aWaW, 2);
        tick;
        applyStimulus(0, 4'd0, 4'd0, 2'b00, 4'd0, 0, 0, 0);
        checkOutput("ld_fwd_s2", aFwd, 4'b1010);
        checkOutput("wb_ld_load", aLoadW, 1);
        checkOutput("wb_ld_wa", aWaW, 4);
        tick;

        // Condition-failed write to r6 must not forward nor write back.
        applyStimulus(1, 4'd0, 4'd0, 2'b00, 4'd6, 1, 0, 0);
        tick;
        aCond = 1'b0;
        applyStimulus(1, 4'd6, 4'd0, 2'b01, 4'd7, 1, 0, 0);
        checkOutput("cond_stall_d", aStallD, 0);
        tick;
        aCond = 1'b1;
        applyStimulus(0, 4'd0, 4'd0, 2'b00, 4'd0, 0, 0, 0);
        checkOutput("cond_no_fwd", aFwd, 0);
        tick;
        checkOutput("cond_we_w", aWeW, 0);
        checkOutput("cond_wa_w", aWaW, 6);

        // MOV PC,r0 -> stall_f/flush_d until it reaches writeback.
        applyStimulus(1, 4'd0, 4'd0, 2'b01, 4'hF, 0, 0, 1);
        checkOutput("pc_d_stall_f", aStallF, 1);
        checkOutput("pc_d_flush_d", aFlushD, 1);
        checkOutput("pc_d_stall_d", aStallD, 0);
        tick;
        applyStimulus(0, 4'd0, 4'd0, 2'b00, 4'd0, 0, 0, 0);
        checkOutput("pc_e_stall_f", aStallF, 1);
        checkOutput("pc_e_pcsrc", aPcsrcW, 0);
        tick;
        checkOutput("pc_s1_stall_f", aStallF, 1);
        checkOutput("pc_s1_flush_d", aFlushD, 1);
        checkOutput("pc_s1_pcsrc", aPcsrcW, 0);
        tick;
        checkOutput("pc_s2_stall_f", aStallF, 0);
        checkOutput("pc_s2_pcsrc", aPcsrcW, 1);
        checkOutput("pc_s2_flush_d", aFlushD, 1);
        tick;
        checkOutput("pc_done_pcsrc", aPcsrcW, 0);
        checkOutput("pc_done_flush_d", aFlushD, 0);

        // Branch coinciding with a load-use stall.
        applyStimulus(1, 4'd0, 4'd0, 2'b01, 4'd8, 1, 1, 0);
        tick;
        aBranch = 1'b1;
        applyStimulus(1, 4'd8, 4'd0, 2'b01, 4'd9, 1, 0, 0);
        checkOutput("br_stall_d", aStallD, 1);
        checkOutput("br_flush_e", aFlushE, 1);
        checkOutput("br_flush_d", aFlushD, 1);
        tick;
        aBranch = 1'b0;
        applyStimulus(0, 4'd0, 4'd0, 2'b00, 4'd0, 0, 0, 0);
        tick;

        // LDR r8 now sits in S2; reset mid-stream discards it.
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_we_w", aWeW, 0);
        checkOutput("mid_rst_load_w", aLoadW, 0);
        checkOutput("mid_rst_wa_w", aWaW, 0);
        checkOutput("mid_rst_fwd", aFwd, 0);
        checkOutput("mid_rst_flush_d", aFlushD, 0);
        tick;
        tick;
        reset = 1'b1;
        applyStimulus(1, 4'd8, 4'd0, 2'b01, 4'd10, 1, 0, 0);
        checkOutput("post_rst_stall_d", aStallD, 0);
        tick;
        applyStimulus(0, 4'd0, 4'd0, 2'b00, 4'd0, 0, 0, 0);
        checkOutput("post_rst_fwd", aFwd, 0);

        // Instance B: load latency 2, dependent at distance 1.
        applyStimulusB(1, 4'd0, 2'b00, 4'd4, 1);
        tick;
        applyStimulusB(1, 4'd4, 2'b01, 4'd5, 0);
        checkOutput("b_d1_stall_1", bStallD, 1);
        tick;
        checkOutput("b_d1_stall_2", bStallD, 1);
        checkOutput("b_d1_flush_e_2", bFlushE, 1);
        tick;
        checkOutput("b_d1_stall_end", bStallD, 0);
        tick;
        applyStimulusB(0, 4'd0, 2'b00, 4'd0, 0);
        checkOutput("b_d1_fwd_s3", bFwd, 4'b0011);
        checkOutput("b_d1_load_w", bLoadW, 1);
        tick;

        // Instance B: dependent at distance 2 stalls one cycle.
        applyStimulusB(1, 4'd0, 2'b00, 4'd4, 1);
        tick;
        applyStimulusB(1, 4'd0, 2'b00, 4'd1, 0);
        checkOutput("b_d2_indep_stall", bStallD, 0);
        tick;
        applyStimulusB(1, 4'd4, 2'b01, 4'd5, 0);
        checkOutput("b_d2_stall_1", bStallD, 1);
        tick;
        checkOutput("b_d2_stall_end", bStallD, 0);
        tick;
        applyStimulusB(0, 4'd0, 2'b00, 4'd0, 0);
        checkOutput("b_d2_fwd_s3", bFwd, 4'b0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
